// File: rtl/fifo_sync_ctr_pkg.sv
// Shared sizing rules for FIFO-based blocks: depth from address width and
// the width of occupancy/threshold values (one bit wider than the address).
package fifo_sync_ctr_pkg;

    function automatic int fifo_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    function automatic int fifo_cnt_bits(input int addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// DEPTH x DATA_BITS dual-port storage: synchronous write port and a
// registered read port whose output holds until the next read.
module fifo_dpram
    import fifo_sync_ctr_pkg::*;
#(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);
    localparam int DEPTH = fifo_depth(ADDR_BITS);

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Registered read port; output register clears on reset so the FIFO
    // presents zero data after reset.
    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_sync_ctr.sv
// Synchronous FIFO with occupancy counter, programmable almost-full /
// almost-empty thresholds, registered read data with valid strobe, and
// sticky overflow/underflow flags. Rejected requests leave state untouched.
module fifo_sync_ctr
    import fifo_sync_ctr_pkg::*;
#(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] fifo_data_in,
    input  logic                 fifo_write,
    input  logic                 fifo_read,
    input  logic [ADDR_BITS:0]   high_limit,
    input  logic [ADDR_BITS:0]   low_limit,
    input  logic                 err_clear,
    output logic [DATA_BITS-1:0] fifo_data_out,
    output logic                 fifo_data_valid,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 fifo_almost_full,
    output logic                 fifo_almost_empty,
    output logic [ADDR_BITS:0]   fifo_count,
    output logic                 overflow_err,
    output logic                 underflow_err
);
    localparam int CNT_BITS = fifo_cnt_bits(ADDR_BITS);
    localparam int DEPTH    = fifo_depth(ADDR_BITS);
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);

    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0]  count;
    logic                 rd_ok, wr_ok;

    // A read frees a slot in the same cycle, so a full FIFO can still
    // accept a write that is paired with a read.
    assign rd_ok = fifo_read & ~fifo_empty;
    assign wr_ok = fifo_write & (~fifo_full | rd_ok);

    // Status flags come from the count register only.
    always_comb begin
        fifo_count        = count;
        fifo_full         = (count == DEPTH_C);
        fifo_empty        = (count == '0);
        fifo_almost_full  = (count >= high_limit);
        fifo_almost_empty = (count <= low_limit);
    end

    // Pointers, occupancy, read strobe and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            fifo_data_valid <= 1'b0;
            overflow_err    <= 1'b0;
            underflow_err   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count           <= count + CNT_BITS'(wr_ok) - CNT_BITS'(rd_ok);
            fifo_data_valid <= rd_ok;
            // A fresh violation beats a simultaneous clear.
            overflow_err    <= (fifo_write & ~wr_ok) | (overflow_err & ~err_clear);
            underflow_err   <= (fifo_read & ~rd_ok)  | (underflow_err & ~err_clear);
        end
    end

    fifo_dpram #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (fifo_data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (fifo_data_out)
    );

endmodule

// File: tb/tb_fifo_sync_ctr.sv
// Bench for fifo_sync_ctr: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_sync_ctr;
    localparam int DB    = 10;
    localparam int AB    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DB-1:0] fifo_data_in = '0;
    logic          fifo_write = 1'b0;
    logic          fifo_read = 1'b0;
    logic [AB:0]   high_limit = 4'd6;
    logic [AB:0]   low_limit = 4'd2;
    logic          err_clear = 1'b0;
    logic [DB-1:0] fifo_data_out;
    logic          fifo_data_valid, fifo_full, fifo_empty;
    logic          fifo_almost_full, fifo_almost_empty;
    logic [AB:0]   fifo_count;
    logic          overflow_err, underflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_sync_ctr #(.DATA_BITS(DB), .ADDR_BITS(AB)) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_data_in      (fifo_data_in),
        .fifo_write        (fifo_write),
        .fifo_read         (fifo_read),
        .high_limit        (high_limit),
        .low_limit         (low_limit),
        .err_clear         (err_clear),
        .fifo_data_out     (fifo_data_out),
        .fifo_data_valid   (fifo_data_valid),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_count        (fifo_count),
        .overflow_err      (overflow_err),
        .underflow_err     (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DB-1:0] m_q[$];
    logic [DB-1:0] m_dout  = '0;
    logic          m_valid = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_udf   = 1'b0;
    bit            m_known = 1'b0;

    always @(posedge clk) begin
        bit rd, wr;
        if (reset) begin
            m_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_known = 1'b1;
        end else begin
            rd = fifo_read && (m_q.size() > 0);
            wr = fifo_write && ((m_q.size() < DEPTH) || rd);
            m_ovf = (fifo_write && !wr) || (m_ovf && !err_clear);
            m_udf = (fifo_read && !rd) || (m_udf && !err_clear);
            m_valid = rd;
            if (rd) m_dout = m_q.pop_front();
            if (wr) m_q.push_back(fifo_data_in);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_known) begin
            chk("count",     32'(fifo_count),        32'(m_q.size()));
            chk("full",      32'(fifo_full),         32'(m_q.size() == DEPTH));
            chk("empty",     32'(fifo_empty),        32'(m_q.size() == 0));
            chk("alm_full",  32'(fifo_almost_full),  32'(m_q.size() >= int'(high_limit)));
            chk("alm_empty", 32'(fifo_almost_empty), 32'(m_q.size() <= int'(low_limit)));
            chk("valid",     32'(fifo_data_valid),   32'(m_valid));
            chk("dout",      32'(fifo_data_out),     32'(m_dout));
            chk("ovf",       32'(overflow_err),      32'(m_ovf));
            chk("udf",       32'(underflow_err),     32'(m_udf));
        end
    end

    // One cycle of stimulus; returns just after the sampling edge.
    task automatic op(input logic w, input logic r, input logic [DB-1:0] d,
                      input logic clr, input logic rst);
        fifo_write   = w;
        fifo_read    = r;
        fifo_data_in = d;
        err_clear    = clr;
        reset        = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        op(0, 0, '0, 0, 1);
        op(0, 0, '0, 0, 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full",  32'(fifo_full), 0);
        chk("rst_ae",    32'(fifo_almost_empty), 1);
        chk("rst_af",    32'(fifo_almost_full), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_dout",  32'(fifo_data_out), 0);

        // 1: fill with 0x001..0x008
        for (int i = 1; i <= 8; i++) begin
            op(1, 0, DB'(i), 0, 0);
            chk("p1_count", 32'(fifo_count), 32'(i));
            chk("p1_af",    32'(fifo_almost_full), 32'(i >= 6));
            chk("p1_full",  32'(fifo_full), 32'(i == 8));
            chk("p1_ae",    32'(fifo_almost_empty), 32'(i <= 2));
        end

        // 2: drain in order
        for (int i = 1; i <= 8; i++) begin
            op(0, 1, '0, 0, 0);
            chk("p2_valid", 32'(fifo_data_valid), 1);
            chk("p2_dout",  32'(fifo_data_out), 32'(i));
        end
        op(0, 0, '0, 0, 0);
        chk("p2_empty", 32'(fifo_empty), 1);
        chk("p2_count", 32'(fifo_count), 0);
        chk("p2_hold",  32'(fifo_data_valid), 0);

        // 3: overflow rejected
        for (int i = 0; i < 8; i++) op(1, 0, DB'(10'h011 + i), 0, 0);
        op(1, 0, 10'h3FF, 0, 0);
        chk("p3_ovf",   32'(overflow_err), 1);
        chk("p3_count", 32'(fifo_count), 8);
        for (int i = 0; i < 8; i++) begin
            op(0, 1, '0, 0, 0);
            chk("p3_dout", 32'(fifo_data_out), 32'(10'h011 + i));
        end

        // 4: underflow rejected, then cleared
        op(0, 1, '0, 0, 0);
        chk("p4_udf",   32'(underflow_err), 1);
        chk("p4_valid", 32'(fifo_data_valid), 0);
        op(0, 0, '0, 1, 0);
        chk("p4_clr_udf", 32'(underflow_err), 0);
        chk("p4_clr_ovf", 32'(overflow_err), 0);

        // 5: simultaneous read/write at full and at empty
        for (int i = 0; i < 8; i++) op(1, 0, DB'(10'h020 + i), 0, 0);
        op(1, 1, 10'h0AA, 0, 0);
        chk("p5_full_count", 32'(fifo_count), 8);
        chk("p5_full_ovf",   32'(overflow_err), 0);
        chk("p5_full_dout",  32'(fifo_data_out), 32'h020);
        for (int i = 0; i < 8; i++) op(0, 1, '0, 0, 0);
        chk("p5_last_dout", 32'(fifo_data_out), 32'h0AA);
        op(1, 1, 10'h055, 0, 0);
        chk("p5_empty_count", 32'(fifo_count), 1);
        chk("p5_empty_udf",   32'(underflow_err), 1);
        op(0, 1, '0, 0, 0);
        chk("p5_dout_055", 32'(fifo_data_out), 32'h055);
        op(0, 0, '0, 1, 0);

        // 6: pointer wrap with steady occupancy 4, then reset mid-burst
        for (int i = 0; i < 4; i++) op(1, 0, DB'(10'h100 + i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            op(1, 1, DB'(10'h104 + i), 0, 0);
            chk("p6_dout",  32'(fifo_data_out), 32'(10'h100 + i));
            chk("p6_count", 32'(fifo_count), 4);
        end
        op(1, 1, 10'h1FF, 0, 1);
        chk("p6_rst_count", 32'(fifo_count), 0);
        chk("p6_rst_empty", 32'(fifo_empty), 1);
        chk("p6_rst_ovf",   32'(overflow_err), 0);
        chk("p6_rst_udf",   32'(underflow_err), 0);
        chk("p6_rst_dout",  32'(fifo_data_out), 0);
        op(0, 0, '0, 0, 0);

        // Threshold corner cases
        high_limit = 4'd0;  low_limit = 4'd8;
        op(0, 0, '0, 0, 0);
        chk("lim_af0", 32'(fifo_almost_full), 1);
        chk("lim_ae8", 32'(fifo_almost_empty), 1);
        high_limit = 4'd9;
        for (int i = 0; i < 8; i++) op(1, 0, DB'(i), 0, 0);
        chk("lim_af9", 32'(fifo_almost_full), 0);
        chk("lim_ae8_full", 32'(fifo_almost_empty), 1);

        // Randomized traffic with phase-biased fill/drain
        for (int i = 0; i < 3000; i++) begin
            bit fill;
            fill = ((i / 150) % 2) == 0;
            if (i % 250 == 0) begin
                high_limit = 4'($urandom_range(0, 15));
                low_limit  = 4'($urandom_range(0, 15));
            end
            op(($urandom_range(0, 3) != 0) ? fill : ~fill & ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 3) != 0) ? ~fill : fill & ($urandom_range(0, 1) == 1),
               DB'($urandom),
               $urandom_range(0, 15) == 0,
               $urandom_range(0, 199) == 0);
        end
        op(0, 0, '0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
